mc_seq: RTL

Parametrised multi-cycle successor to the single-cycle core top. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and talks to instruction and data memory over req/ack handshakes, so memories may insert wait states. It owns the PC, the instruction register and the writeback strobes. The ALU and register file stay external and are driven from `instr` and `rf_*`.

---
 rtl/mc_seq.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mc_seq.sv
// rtl/mc_seq.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with req/ack memories
// Optional feature macro: MC_SEQ_PERF_EN (cycle and retired-instruction counters).
module mc_seq #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RESET,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic [XLEN-1:0] alu_out,
  input  logic            zf,
  input  logic [XLEN-1:0] rt_val,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            halted,
  output logic [2:0]      state,
  output logic [31:0]     cyc_cnt,
  output logic [31:0]     ret_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  state_t          st;
  logic [XLEN-1:0] pc_q, alu_q, rt_q, mem_q, pc_plus4, br_off, pc_next;
  logic [31:0]     instr_q;
  logic            zf_q, dmem_req_q, dmem_we_q, rf_we_q, halted_q;
  logic [5:0]      opcode;
  logic            is_rtype, is_alui, is_lw, is_sw, is_beq, is_j, is_halt, taken;

  assign opcode   = instr_q[31:26];
  assign is_rtype = (opcode == 6'b000000);
  assign is_alui  = (opcode[5:3] == 3'b001);
  assign is_lw    = (opcode == 6'b100011);
  assign is_sw    = (opcode == 6'b101011);
  assign is_beq   = (opcode == 6'b000100);
  assign is_j     = (opcode == 6'b000010);
  assign is_halt  = (opcode == 6'b111111);

  // beq leaves straight from EXEC, before zf_q has been loaded
  assign taken    = is_beq && ((st == S_EXEC) ? zf : zf_q);
  assign pc_plus4 = pc_q + FOUR;
  assign br_off   = {{(XLEN-18){instr_q[15]}}, instr_q[15:0], 2'b00};

  always_comb begin
    pc_next = pc_plus4;
    if (taken)
      pc_next = pc_plus4 + br_off;
    else if (is_j)
      pc_next = {pc_plus4[XLEN-1:28], instr_q[25:0], 2'b00};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      st         <= S_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      alu_q      <= '0;
      rt_q       <= '0;
      mem_q      <= '0;
      zf_q       <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (st)
        S_FETCH: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            st      <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_halt) begin
            st       <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            st <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_q <= alu_out;
          zf_q  <= zf;
          rt_q  <= rt_val;
          if (is_lw || is_sw) begin
            st         <= S_MEM;
            dmem_req_q <= 1'b1;
            dmem_we_q  <= is_sw;
          end else if (is_rtype || is_alui) begin
            st      <= S_WB;
            rf_we_q <= 1'b1;
          end else begin
            pc_q <= pc_next;
            st   <= S_FETCH;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (is_lw) begin
              mem_q   <= dmem_rdata;
              rf_we_q <= 1'b1;
              st      <= S_WB;
            end else begin
              pc_q <= pc_next;
              st   <= S_FETCH;
            end
          end
        end
        S_WB: begin
          rf_we_q <= 1'b0;
          pc_q    <= pc_next;
          st      <= S_FETCH;
        end
        S_HALT:  st <= S_HALT;
        default: st <= S_FETCH;
      endcase
    end
  end

  // Gated by RESET so an in-flight fetch is withdrawn the moment reset asserts
  assign imem_req   = (st == S_FETCH) && !RESET;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = alu_q;
  assign dmem_wdata = rt_q;
  assign pc         = pc_q;
  assign instr      = instr_q;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = is_rtype ? instr_q[15:11] : instr_q[20:16];
  assign rf_wdata   = is_lw ? mem_q : alu_q;
  assign halted     = halted_q;
  assign state      = st;

`ifdef MC_SEQ_PERF_EN
  logic        retire;
  logic [31:0] cyc_q, ret_q;

  // Final-state exits of every class, plus the DECODE->HALT transition
  assign retire = ((st == S_EXEC) && !(is_lw || is_sw || is_rtype || is_alui)) ||
                  ((st == S_MEM) && dmem_ack && !is_lw) ||
                  (st == S_WB) ||
                  ((st == S_DECODE) && is_halt);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (st != S_HALT)
        cyc_q <= cyc_q + 32'd1;
      if (retire)
        ret_q <= ret_q + 32'd1;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;
`else
  assign cyc_cnt = '0;
  assign ret_cnt = '0;
`endif

endmodule
